ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words of storage; word index is haddr[log2(DEPTH)+1:2], and upper address bits alias.
REQ-002 Parameter WAIT_STATES, default 1, number of hreadyout-low cycles inserted before each OKAY data-phase completion; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hsel  input  1  slave select from the bus decoder.
REQ-006 haddr  input  32  address-phase byte address.
REQ-007 htrans  input  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 hwrite  input  1  address-phase direction; 1 = write.
REQ-009 hsize  input  3  address-phase size: 0 byte, 1 halfword, 2 word.
REQ-010 hwdata  input  32  write data, valid in the data phase.
REQ-011 hready  input  1  bus-level ready; an address phase is sampled only when this is high.
REQ-012 hreadyout  output  1  slave ready for the current data phase.
REQ-013 hresp  output  1  0 OKAY, 1 ERROR.
REQ-014 hrdata  output  32  read data, valid on the read completion cycle.

Function
REQ-015 An address phase is accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1; address, size, direction and byte offset are captured in that cycle.
REQ-016 An accepted transfer is erroneous in any of these cases: hsize>2; hsize=1 with haddr[0]=1; hsize=2 with haddr[1:0]!=0.
REQ-017 FSM states: IDLE, WAIT, XFER, ERR1, ERR2.
REQ-018 IDLE: hreadyout=1, hresp=0. On an accepted erroneous transfer, go to ERR1. On an accepted valid transfer, go to WAIT if WAIT_STATES>0, otherwise to XFER. With no accepted transfer, stay in IDLE.
REQ-019 WAIT: hreadyout=0, hresp=0. A down-counter loaded with WAIT_STATES on entry decrements each cycle; go to XFER after exactly WAIT_STATES cycles in WAIT.
REQ-020 XFER: hreadyout=1, hresp=0; this is the completion cycle. A new address phase accepted in XFER is handled as from IDLE (pipelined back-to-back); with none accepted, go to IDLE.
REQ-021 ERR1: hreadyout=0, hresp=1; next state is ERR2. No address phase is sampled in ERR1.
REQ-022 ERR2: hreadyout=1, hresp=1. An address phase accepted here is handled as from IDLE; otherwise go to IDLE.
REQ-023 Erroneous transfers never modify storage and drive hrdata=0.
REQ-024 Writes commit at the rising edge that ends the XFER cycle, using hwdata sampled in that cycle. Byte lanes are little-endian: byte at lane haddr[1:0]; halfword at lanes {haddr[1],0}+1..+0; word uses all lanes. Unselected lanes are unchanged.
REQ-025 Reads: in XFER, hrdata = full 32-bit word at the captured index, with no lane masking; in all other cycles, hrdata=0.
REQ-026 A read whose data phase follows a write to the same word returns the newly written data.
REQ-027 Sampling is gated by hready, so stalls caused by other slaves (hready=0 with hsel=1) are ignored.
REQ-028 htrans IDLE or BUSY with hsel=1 produces a zero-wait OKAY; state stays in IDLE.

Reset
REQ-029 While reset=1, asynchronously: FSM=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, all storage words=0.
REQ-030 Reset asserted mid-transfer (WAIT, XFER or ERR1) abandons the transfer; a pending write is not committed.
REQ-031 After reset deassertion, the first accepted address phase may occur on the first rising edge.

Verification
REQ-032 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase has 1 cycle of hreadyout=0; the read returns 0xDEADBEEF with hresp=0.
REQ-033 Byte write 0xAB at 0x13 over a word holding 0x11223344 -> a subsequent read of 0x10 returns 0xAB223344.
REQ-034 Halfword write at 0x21 -> cycle 1: hresp=1, hreadyout=0; cycle 2: hresp=1, hreadyout=1; a read of 0x20 returns 0x00000000.
REQ-035 WAIT_STATES=0: back-to-back NONSEQ writes to 0x0, 0x4, 0x8 followed by reads -> hreadyout is high every cycle and the reads return the written values in order.
REQ-036 Reset asserted during WAIT of a write to 0x30 -> outputs return to reset values immediately; a read of 0x30 after reset returns 0.
REQ-037 hsel=1, htrans=NONSEQ, hready=0 for 3 cycles -> no transfer is captured and hreadyout stays 1; storage is unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite slave backed by a flop-based word array.
//   Each accepted transfer takes WAIT_STATES stall cycles before it
//   completes with OKAY. Misaligned or oversized transfers get the
//   two-cycle ERROR response and leave storage untouched.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   hsel       slave select
//   haddr      address-phase byte address
//   htrans     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     address-phase direction, 1 = write
//   hsize      address-phase size (0 byte, 1 halfword, 2 word)
//   hwdata     data-phase write data
//   hready     bus-level ready; the address phase is sampled only when high
//   hreadyout  slave ready for the current data phase
//   hresp      0 OKAY, 1 ERROR
//   hrdata     read data, non-zero only on a read completion cycle
//
// FSM
//   state | meaning
//   IDLE  | no data phase in progress, ready for an address phase
//   WAIT  | valid transfer stalled by the wait-state down-counter
//   XFER  | completion cycle; reads drive hrdata, writes commit at its end
//   ERR1  | first ERROR cycle (hreadyout low)
//   ERR2  | second ERROR cycle (hreadyout high), may accept a new transfer
module ahb_sram_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    wait_cnt;
  logic          load_cnt;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_off;
  logic [1:0]    cap_size;
  logic          cap_write;
  logic [31:0]   mem [DEPTH];

  logic          can_sample;
  logic          accept;
  logic          addr_err;
  logic [3:0]    byte_en;
  logic [31:0]   wmask;

  // Address bits above the word index alias; htrans[0] only separates SEQ from NONSEQ.
  logic unused_bits;
  assign unused_bits = ^{haddr[31:AW+2], htrans[0]};

  // The address phase is only looked at in cycles where this slave shows hreadyout=1.
  assign can_sample = (state == ST_IDLE) || (state == ST_XFER) || (state == ST_ERR2);
  assign accept     = can_sample && hsel && hready && htrans[1];

  assign addr_err = (hsize > 3'd2) ||
                    ((hsize == 3'd1) && haddr[0]) ||
                    ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    load_cnt  = 1'b0;
    case (state)
      ST_IDLE, ST_XFER, ST_ERR2: begin
        hresp = (state == ST_ERR2);
        if (accept) begin
          if (addr_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            load_cnt  = 1'b1;
          end else begin
            state_nxt = ST_XFER;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        // Terminal count: the counter reads 1 in the last stall cycle.
        if (wait_cnt <= 3'd1) begin
          state_nxt = ST_XFER;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 3'd0;
    end else if (load_cnt) begin
      wait_cnt <= 3'(WAIT_STATES);
    end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_idx   <= '0;
      cap_off   <= 2'b00;
      cap_size  <= 2'b00;
      cap_write <= 1'b0;
    end else if (accept && !addr_err) begin
      cap_idx   <= haddr[AW+1:2];
      cap_off   <= haddr[1:0];
      cap_size  <= hsize[1:0];
      cap_write <= hwrite;
    end
  end

  always_comb begin
    case (cap_size)
      2'd0:    byte_en = 4'b0001 << cap_off;
      2'd1:    byte_en = cap_off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  assign wmask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

  // The write lands on the edge that ends XFER, so a following read's XFER sees it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == ST_XFER) && cap_write) begin
      mem[cap_idx] <= (mem[cap_idx] & ~wmask) | (hwdata & wmask);
    end
  end

  assign hrdata = ((state == ST_XFER) && !cap_write) ? mem[cap_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Directed bench for ahb_sram_slave. Instance 0 runs with one wait state,
//   instance 1 with zero wait states for pipelined back-to-back traffic.
//   Read expectations come from a byte-lane model and pass through a
//   scoreboard queue between the address phase and the completion cycle.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold_lo;

  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  logic [31:0] model_mem [2][64];
  logic [31:0] exp_q [$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Single slave on each bus: hready follows hreadyout unless a foreign stall is forced.
  assign hready[0] = hold_lo ? 1'b0 : hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_sram_slave #(.DEPTH(64), .WAIT_STATES(1)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel[0]),
    .haddr     (haddr[0]),
    .htrans    (htrans[0]),
    .hwrite    (hwrite[0]),
    .hsize     (hsize[0]),
    .hwdata    (hwdata[0]),
    .hready    (hready[0]),
    .hreadyout (hreadyout[0]),
    .hresp     (hresp[0]),
    .hrdata    (hrdata[0])
  );

  ahb_sram_slave #(.DEPTH(64), .WAIT_STATES(0)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel[1]),
    .haddr     (haddr[1]),
    .htrans    (htrans[1]),
    .hwrite    (hwrite[1]),
    .hsize     (hsize[1]),
    .hwdata    (hwdata[1]),
    .hready    (hready[1]),
    .hreadyout (hreadyout[1]),
    .hresp     (hresp[1]),
    .hrdata    (hrdata[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] r;
    logic        sel;
    r = old;
    for (int b = 0; b < 4; b++) begin
      case (size)
        3'd0:    sel = (b == int'(addr[1:0]));
        3'd1:    sel = ((b / 2) == int'(addr[1]));
        default: sel = 1'b1;
      endcase
      if (sel) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        model_mem[d][i] = 32'h0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, obs, e);
    end
  endtask

  // One isolated transfer on instance d: address phase, then the data phase to completion.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic exp_err, input int exp_waits,
                      input string tag);
    int waits;
    logic done;
    @(negedge clk);
    hsel[d] = 1'b1; htrans[d] = 2'd2; haddr[d] = addr; hwrite[d] = wr; hsize[d] = size;
    if (!wr && !exp_err) exp_q.push_back(model_mem[d][addr[7:2]]);
    @(negedge clk);
    hsel[d] = 1'b0; htrans[d] = 2'd0; hwdata[d] = wdata;
    if (exp_err) begin
      check({tag, "_err1_rdy"},  32'(hreadyout[d]), 32'd0);
      check({tag, "_err1_resp"}, 32'(hresp[d]),     32'd1);
      check({tag, "_err1_rdata"}, hrdata[d],        32'h0);
      @(negedge clk);
      check({tag, "_err2_rdy"},  32'(hreadyout[d]), 32'd1);
      check({tag, "_err2_resp"}, 32'(hresp[d]),     32'd1);
      check({tag, "_err2_rdata"}, hrdata[d],        32'h0);
    end else begin
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 16 && !done; i++) begin
        if (hreadyout[d]) done = 1'b1;
        else begin
          check({tag, "_wait_resp"}, 32'(hresp[d]), 32'd0);
          waits++;
          @(negedge clk);
        end
      end
      check({tag, "_done"},  32'(done),     32'd1);
      check({tag, "_waits"}, 32'(waits),    32'(exp_waits));
      check({tag, "_resp"},  32'(hresp[d]), 32'd0);
      if (!wr) pop_check(tag, hrdata[d]);
      else model_mem[d][addr[7:2]] = merge(model_mem[d][addr[7:2]], wdata, addr, size);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        p_wr   [6];
    logic [31:0] p_addr [6];
    logic [31:0] p_data [6];
    logic        prev_valid, prev_wr;
    logic [31:0] prev_addr, prev_data;

    reset   = 1'b1;
    hold_lo = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'd0; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hwdata[d] = 32'h0;
    end
    clear_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_rdy", d),   32'(hreadyout[d]), 32'd1);
      check($sformatf("rst%0d_resp", d),  32'(hresp[d]),     32'd0);
      check($sformatf("rst%0d_rdata", d), hrdata[d],         32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Word write then read, one wait state each
    xfer(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1, "w_word10");
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 1, "r_word10");

    // Byte write into lane 3
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, 1'b0, 1, "w_base10");
    xfer(0, 32'h13, 1'b1, 3'd0, 32'hAB000000, 1'b0, 1, "w_byte13");
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 1, "r_byte10");
    check("byte_lane_literal", model_mem[0][4], 32'hAB223344);

    // Misaligned halfword: error response, storage untouched
    xfer(0, 32'h21, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 0, "e_half21");
    xfer(0, 32'h20, 1'b0, 3'd2, 32'h0,        1'b0, 1, "r_after_err20");

    // Other error cases, including an erroneous read
    xfer(0, 32'h40, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 0, "e_size3");
    xfer(0, 32'h42, 1'b0, 3'd2, 32'h0,        1'b1, 0, "e_word42");

    // Halfword and byte lanes
    xfer(0, 32'h22, 1'b1, 3'd1, 32'hBEEF1234, 1'b0, 1, "w_half22");
    xfer(0, 32'h24, 1'b1, 3'd1, 32'hCAFEF00D, 1'b0, 1, "w_half24");
    xfer(0, 32'h25, 1'b1, 3'd0, 32'h00007700, 1'b0, 1, "w_byte25");
    xfer(0, 32'h20, 1'b0, 3'd2, 32'h0,        1'b0, 1, "r_half20");
    xfer(0, 32'h24, 1'b0, 3'd2, 32'h0,        1'b0, 1, "r_half24");
    // Upper address bits alias onto the same word
    xfer(0, 32'h0000_1124, 1'b0, 3'd2, 32'h0, 1'b0, 1, "r_alias24");

    // Foreign stall: hready low while selected with NONSEQ write
    @(negedge clk);
    hold_lo = 1'b1;
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h10; hwrite[0] = 1'b1;
    hsize[0] = 3'd2; hwdata[0] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rdy", i),  32'(hreadyout[0]), 32'd1);
      check($sformatf("stall%0d_resp", i), 32'(hresp[0]),     32'd0);
    end
    hsel[0] = 1'b0; htrans[0] = 2'd0;
    hold_lo = 1'b0;
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1, "r_after_stall");

    // IDLE and BUSY while selected: zero-wait OKAY
    @(negedge clk);
    hsel[0] = 1'b1; htrans[0] = 2'd0; hwrite[0] = 1'b1; haddr[0] = 32'h10;
    @(negedge clk);
    check("idle_rdy",  32'(hreadyout[0]), 32'd1);
    check("idle_resp", 32'(hresp[0]),     32'd0);
    htrans[0] = 2'd1;
    @(negedge clk);
    check("busy_rdy",  32'(hreadyout[0]), 32'd1);
    check("busy_resp", 32'(hresp[0]),     32'd0);
    hsel[0] = 1'b0; htrans[0] = 2'd0; hwrite[0] = 1'b0;
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1, "r_after_busy");

    // Zero wait states, pipelined writes then reads
    p_wr[0] = 1'b1; p_addr[0] = 32'h0; p_data[0] = 32'h01234567;
    p_wr[1] = 1'b1; p_addr[1] = 32'h4; p_data[1] = 32'h89ABCDEF;
    p_wr[2] = 1'b1; p_addr[2] = 32'h8; p_data[2] = 32'h0F0F0F0F;
    p_wr[3] = 1'b0; p_addr[3] = 32'h0; p_data[3] = 32'h0;
    p_wr[4] = 1'b0; p_addr[4] = 32'h4; p_data[4] = 32'h0;
    p_wr[5] = 1'b0; p_addr[5] = 32'h8; p_data[5] = 32'h0;
    prev_valid = 1'b0; prev_wr = 1'b0; prev_addr = 32'h0; prev_data = 32'h0;
    @(negedge clk);
    for (int i = 0; i <= 6; i++) begin
      if (prev_valid) begin
        check($sformatf("pipe%0d_rdy", i),  32'(hreadyout[1]), 32'd1);
        check($sformatf("pipe%0d_resp", i), 32'(hresp[1]),     32'd0);
        if (prev_wr) begin
          hwdata[1] = prev_data;
          model_mem[1][prev_addr[7:2]] = merge(model_mem[1][prev_addr[7:2]], prev_data, prev_addr, 3'd2);
        end else begin
          pop_check($sformatf("pipe%0d", i), hrdata[1]);
        end
      end
      if (i < 6) begin
        hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = p_addr[i]; hwrite[1] = p_wr[i]; hsize[1] = 3'd2;
        if (!p_wr[i]) exp_q.push_back(model_mem[1][p_addr[i][7:2]]);
        prev_valid = 1'b1; prev_wr = p_wr[i]; prev_addr = p_addr[i]; prev_data = p_data[i];
      end else begin
        hsel[1] = 1'b0; htrans[1] = 2'd0;
        prev_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("pipe_end_rdy", 32'(hreadyout[1]), 32'd1);
    check("pipe_end_rdata", hrdata[1], 32'h0);

    // Reset during the wait state of a write to 0x30
    @(negedge clk);
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h30; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    @(negedge clk);
    hsel[0] = 1'b0; htrans[0] = 2'd0; hwdata[0] = 32'h55AA55AA;
    check("mid_wait_rdy", 32'(hreadyout[0]), 32'd0);
    reset = 1'b1;
    #1;
    check("async_rst_rdy",   32'(hreadyout[0]), 32'd1);
    check("async_rst_resp",  32'(hresp[0]),     32'd0);
    check("async_rst_rdata", hrdata[0],         32'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    xfer(0, 32'h30, 1'b0, 3'd2, 32'h0, 1'b0, 1, "r_after_rst30");
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1, "r_after_rst10");
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
